// File: rtl/bolme_birimi_pkg.sv
// Shared types and constants for the sequential RV32M divider.
// The execute stage uses the funct3 codes to derive the signed and remainder selects.
package bolme_birimi_pkg;

  localparam int BOLME_SAYAC_BIT = 5;

  typedef enum logic [1:0] {
    BOLME_BOSTA  = 2'd0,
    BOLME_BOL    = 2'd1,
    BOLME_DUZELT = 2'd2
  } bolme_durum_t;

  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } rv32m_bolme_f3_t;

endpackage

// File: rtl/bolme_adimi.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, then keep the subtraction only if it did not borrow.
module bolme_adimi #(
  parameter int VERI_BIT = 32
) (
  input  logic [VERI_BIT-1:0] kalan,
  input  logic [VERI_BIT-1:0] bolum,
  input  logic [VERI_BIT-1:0] bolen,
  output logic [VERI_BIT-1:0] kalan_yeni,
  output logic [VERI_BIT-1:0] bolum_yeni
);

  logic [VERI_BIT:0] kaydirilmis;
  logic [VERI_BIT:0] fark;

  always_comb begin
    kaydirilmis = {kalan, bolum[VERI_BIT-1]};
    // The 33-bit difference's top bit is the borrow, i.e. the compare result.
    fark        = kaydirilmis - {1'b0, bolen};
    if (!fark[VERI_BIT]) begin
      kalan_yeni = fark[VERI_BIT-1:0];
      bolum_yeni = {bolum[VERI_BIT-2:0], 1'b1};
    end else begin
      kalan_yeni = kaydirilmis[VERI_BIT-1:0];
      bolum_yeni = {bolum[VERI_BIT-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/bolme_birimi.sv
// Sequential 32-bit divider for div/divu/rem/remu: one quotient bit per clock,
// with divide-by-zero and signed overflow resolved in a single cycle.
module bolme_birimi
  import bolme_birimi_pkg::*;
#(
  parameter int VERI_BIT = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                basla_i,
  input  logic                iptal_i,
  input  logic [VERI_BIT-1:0] bolunen_i,
  input  logic [VERI_BIT-1:0] bolen_i,
  input  logic                isaretli_i,
  input  logic                kalan_sec_i,
  output logic [VERI_BIT-1:0] sonuc_o,
  output logic                mesgul_o,
  output logic                bitti_o
);

  localparam logic [VERI_BIT-1:0] EN_NEGATIF = {1'b1, {(VERI_BIT-1){1'b0}}};
  localparam logic [BOLME_SAYAC_BIT-1:0] SAYAC_BASLANGIC = BOLME_SAYAC_BIT'(VERI_BIT - 1);

  bolme_durum_t durum, durum_sonraki;

  logic [BOLME_SAYAC_BIT-1:0] sayac;
  logic [VERI_BIT-1:0] kalan, bolum, bolen;
  logic [VERI_BIT-1:0] kalan_adim, bolum_adim;
  logic [VERI_BIT-1:0] bolunen_mutlak, bolen_mutlak;
  logic [VERI_BIT-1:0] bolum_son, kalan_son;
  logic kalan_sec, bolum_isaret, kalan_isaret, duzelt;
  logic sifira_bolme, tasma;

  bolme_adimi #(.VERI_BIT(VERI_BIT)) u_adim (
    .kalan      (kalan),
    .bolum      (bolum),
    .bolen      (bolen),
    .kalan_yeni (kalan_adim),
    .bolum_yeni (bolum_adim)
  );

  // Operand decode; |0x80000000| stays 0x80000000 and is used as unsigned.
  always_comb begin
    sifira_bolme   = (bolen_i == '0);
    tasma          = isaretli_i && (bolunen_i == EN_NEGATIF) && (bolen_i == '1);
    bolunen_mutlak = (isaretli_i && bolunen_i[VERI_BIT-1]) ? -bolunen_i : bolunen_i;
    bolen_mutlak   = (isaretli_i && bolen_i[VERI_BIT-1])   ? -bolen_i   : bolen_i;
    bolum_son      = (duzelt && bolum_isaret) ? -bolum : bolum;
    kalan_son      = (duzelt && kalan_isaret) ? -kalan : kalan;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (rst_i) durum <= BOLME_BOSTA;
    else       durum <= durum_sonraki;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    durum_sonraki = durum;
    mesgul_o      = (durum != BOLME_BOSTA);
    unique case (durum)
      BOLME_BOSTA: begin
        if (basla_i) durum_sonraki = (sifira_bolme || tasma) ? BOLME_DUZELT : BOLME_BOL;
      end
      BOLME_BOL: begin
        if (sayac == '0) durum_sonraki = BOLME_DUZELT;
      end
      BOLME_DUZELT: durum_sonraki = BOLME_BOSTA;
      default:      durum_sonraki = BOLME_BOSTA;
    endcase
    if (iptal_i) durum_sonraki = BOLME_BOSTA;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac        <= '0;
      kalan        <= '0;
      bolum        <= '0;
      bolen        <= '0;
      kalan_sec    <= 1'b0;
      bolum_isaret <= 1'b0;
      kalan_isaret <= 1'b0;
      duzelt       <= 1'b0;
      sonuc_o      <= '0;
      bitti_o      <= 1'b0;
    end else begin
      bitti_o <= 1'b0;
      if (!iptal_i) begin
        unique case (durum)
          BOLME_BOSTA: begin
            if (basla_i) begin
              kalan_sec    <= kalan_sec_i;
              bolum_isaret <= isaretli_i && (bolunen_i[VERI_BIT-1] ^ bolen_i[VERI_BIT-1]);
              kalan_isaret <= isaretli_i && bolunen_i[VERI_BIT-1];
              sayac        <= SAYAC_BASLANGIC;
              bolen        <= bolen_mutlak;
              if (sifira_bolme) begin
                bolum  <= '1;
                kalan  <= bolunen_i;
                duzelt <= 1'b0;
              end else if (tasma) begin
                bolum  <= EN_NEGATIF;
                kalan  <= '0;
                duzelt <= 1'b0;
              end else begin
                bolum  <= bolunen_mutlak;
                kalan  <= '0;
                duzelt <= isaretli_i;
              end
            end
          end
          BOLME_BOL: begin
            kalan <= kalan_adim;
            bolum <= bolum_adim;
            if (sayac != '0) sayac <= sayac - 1'b1;
          end
          BOLME_DUZELT: begin
            sonuc_o <= kalan_sec ? kalan_son : bolum_son;
            bitti_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bolme_birimi.sv
// Directed self-checking bench for bolme_birimi: results, latency, handshake,
// flush and asynchronous reset behaviour.
module tb_bolme_birimi;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        basla_i = 1'b0;
  logic        iptal_i = 1'b0;
  logic [31:0] bolunen_i = '0;
  logic [31:0] bolen_i = '0;
  logic        isaretli_i = 1'b0;
  logic        kalan_sec_i = 1'b0;
  logic [31:0] sonuc_o;
  logic        mesgul_o;
  logic        bitti_o;

  int dogrulama = 0;
  int hata = 0;

  bolme_birimi #(.VERI_BIT(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .basla_i     (basla_i),
    .iptal_i     (iptal_i),
    .bolunen_i   (bolunen_i),
    .bolen_i     (bolen_i),
    .isaretli_i  (isaretli_i),
    .kalan_sec_i (kalan_sec_i),
    .sonuc_o     (sonuc_o),
    .mesgul_o    (mesgul_o),
    .bitti_o     (bitti_o)
  );

  always #5 clk_i = ~clk_i;

  // Called 1 time unit after a rising edge; returns 1 time unit after edge 0.
  // Operands are scrambled afterwards since they only need to hold on edge 0.
  task automatic basla_sur(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic k);
    bolunen_i   = a;
    bolen_i     = b;
    isaretli_i  = s;
    kalan_sec_i = k;
    basla_i     = 1'b1;
    @(posedge clk_i);
    #1;
    basla_i     = 1'b0;
    bolunen_i   = $urandom;
    bolen_i     = $urandom;
    isaretli_i  = ~s;
    kalan_sec_i = ~k;
  endtask

  // Counts edges after edge 0 until bitti_o; -1 if the budget expires.
  task automatic bitti_bekle(input int sinir, output int gecikme);
    gecikme = -1;
    for (int n = 1; n <= sinir; n++) begin
      @(posedge clk_i);
      #1;
      if (bitti_o === 1'b1) begin
        gecikme = n;
        break;
      end
    end
  endtask

  task automatic islem(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic k, output logic [31:0] sonuc, output int gecikme);
    basla_sur(a, b, s, k);
    bitti_bekle(40, gecikme);
    sonuc = sonuc_o;
  endtask

  task automatic test_reset;
    #2 rst_i = 1'b1;
    #2;
    dogrulama++;
    if (sonuc_o !== 32'h0) begin hata++; $display("FAIL reset_sonuc: got %h expected %h", sonuc_o, 32'h0); end
    dogrulama++;
    if (mesgul_o !== 1'b0) begin hata++; $display("FAIL reset_mesgul: got %b expected 0", mesgul_o); end
    dogrulama++;
    if (bitti_o !== 1'b0) begin hata++; $display("FAIL reset_bitti: got %b expected 0", bitti_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_unsigned;
    int g;
    basla_sur(32'd100, 32'd7, 1'b0, 1'b0);
    dogrulama++;
    if (mesgul_o !== 1'b1) begin hata++; $display("FAIL u_mesgul_edge0: got %b expected 1", mesgul_o); end
    bitti_bekle(40, g);
    dogrulama++;
    if (g != 33) begin hata++; $display("FAIL u_latency: got %0d expected 33", g); end
    dogrulama++;
    if (sonuc_o !== 32'd14) begin hata++; $display("FAIL u_100_7_q: got %h expected %h", sonuc_o, 32'd14); end
    dogrulama++;
    if (mesgul_o !== 1'b0) begin hata++; $display("FAIL u_mesgul_done: got %b expected 0", mesgul_o); end
    @(posedge clk_i);
    #1;
    dogrulama++;
    if (bitti_o !== 1'b0) begin hata++; $display("FAIL u_bitti_one_cycle: got %b expected 0", bitti_o); end
    dogrulama++;
    if (sonuc_o !== 32'd14) begin hata++; $display("FAIL u_sonuc_hold: got %h expected %h", sonuc_o, 32'd14); end
    basla_sur(32'd100, 32'd7, 1'b0, 1'b1);
    bitti_bekle(40, g);
    dogrulama++;
    if (sonuc_o !== 32'd2 || g != 33) begin
      hata++; $display("FAIL u_100_7_r: got %h lat %0d expected %h lat 33", sonuc_o, g, 32'd2);
    end
  endtask

  task automatic test_signed;
    logic [31:0] r;
    int g;
    islem(32'hFFFF_FFF9, 32'd3, 1'b1, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'hFFFF_FFFE || g != 33) begin hata++; $display("FAIL s_m7_3_q: got %h lat %0d expected fffffffe lat 33", r, g); end
    islem(32'hFFFF_FFF9, 32'd3, 1'b1, 1'b1, r, g);
    dogrulama++;
    if (r !== 32'hFFFF_FFFF) begin hata++; $display("FAIL s_m7_3_r: got %h expected ffffffff", r); end
    islem(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'hFFFF_FFFE) begin hata++; $display("FAIL s_7_m3_q: got %h expected fffffffe", r); end
    islem(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, r, g);
    dogrulama++;
    if (r !== 32'h0000_0001) begin hata++; $display("FAIL s_7_m3_r: got %h expected 00000001", r); end
    islem(32'h8000_0000, 32'd2, 1'b1, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'hC000_0000) begin hata++; $display("FAIL s_min_2_q: got %h expected c0000000", r); end
  endtask

  task automatic test_div_zero;
    logic [31:0] r;
    int g;
    for (int s = 0; s < 2; s++) begin
      islem(32'd5, 32'd0, s[0], 1'b0, r, g);
      dogrulama++;
      if (r !== 32'hFFFF_FFFF || g != 1) begin
        hata++; $display("FAIL dz_q_signed%0d: got %h lat %0d expected ffffffff lat 1", s, r, g);
      end
      islem(32'd5, 32'd0, s[0], 1'b1, r, g);
      dogrulama++;
      if (r !== 32'd5 || g != 1) begin
        hata++; $display("FAIL dz_r_signed%0d: got %h lat %0d expected 00000005 lat 1", s, r, g);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    int g;
    islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'h8000_0000 || g != 1) begin hata++; $display("FAIL ov_s_q: got %h lat %0d expected 80000000 lat 1", r, g); end
    islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, r, g);
    dogrulama++;
    if (r !== 32'h0 || g != 1) begin hata++; $display("FAIL ov_s_r: got %h lat %0d expected 00000000 lat 1", r, g); end
    islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'h0 || g != 33) begin hata++; $display("FAIL ov_u_q: got %h lat %0d expected 00000000 lat 33", r, g); end
    islem(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, r, g);
    dogrulama++;
    if (r !== 32'h8000_0000 || g != 33) begin hata++; $display("FAIL ov_u_r: got %h lat %0d expected 80000000 lat 33", r, g); end
  endtask

  // Each new start is driven in the very cycle bitti_o is observed high.
  task automatic test_back_to_back;
    logic [31:0] r;
    int g;
    islem(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'h7FFF_FFFF || g != 33) begin hata++; $display("FAIL b2b_q1: got %h lat %0d expected 7fffffff lat 33", r, g); end
    islem(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, r, g);
    dogrulama++;
    if (r !== 32'h1 || g != 33) begin hata++; $display("FAIL b2b_r1: got %h lat %0d expected 00000001 lat 33", r, g); end
    islem(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'h1 || g != 33) begin hata++; $display("FAIL b2b_q2: got %h lat %0d expected 00000001 lat 33", r, g); end
    islem(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, r, g);
    dogrulama++;
    if (r !== 32'h0 || g != 33) begin hata++; $display("FAIL b2b_r2: got %h lat %0d expected 00000000 lat 33", r, g); end
  endtask

  task automatic test_abort;
    logic [31:0] r;
    int g;
    islem(32'd100, 32'd7, 1'b0, 1'b0, r, g);
    basla_sur(32'd1000, 32'd10, 1'b0, 1'b0);
    bitti_bekle(10, g);
    dogrulama++;
    if (g != -1) begin hata++; $display("FAIL abort_early_done: got lat %0d expected none", g); end
    iptal_i = 1'b1;
    @(posedge clk_i);
    #1;
    iptal_i = 1'b0;
    dogrulama++;
    if (mesgul_o !== 1'b0 || bitti_o !== 1'b0) begin
      hata++; $display("FAIL abort_flags: got mesgul %b bitti %b expected 0 0", mesgul_o, bitti_o);
    end
    dogrulama++;
    if (sonuc_o !== 32'd14) begin hata++; $display("FAIL abort_sonuc_hold: got %h expected %h", sonuc_o, 32'd14); end
    islem(32'd1000, 32'd10, 1'b0, 1'b0, r, g);
    dogrulama++;
    if (r !== 32'd100 || g != 33) begin hata++; $display("FAIL abort_restart: got %h lat %0d expected %h lat 33", r, g, 32'd100); end
    // Flush and start together: flush wins, nothing runs.
    iptal_i = 1'b1;
    basla_sur(32'd100, 32'd7, 1'b0, 1'b1);
    iptal_i = 1'b0;
    dogrulama++;
    if (mesgul_o !== 1'b0) begin hata++; $display("FAIL abort_with_start_mesgul: got %b expected 0", mesgul_o); end
    bitti_bekle(40, g);
    dogrulama++;
    if (g != -1 || sonuc_o !== 32'd100) begin
      hata++; $display("FAIL abort_with_start_done: got lat %0d sonuc %h expected none %h", g, sonuc_o, 32'd100);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int g;
    basla_sur(32'd1000, 32'd7, 1'b0, 1'b0);
    bitti_bekle(20, g);
    dogrulama++;
    if (g != -1) begin hata++; $display("FAIL rst_mid_early_done: got lat %0d expected none", g); end
    #2 rst_i = 1'b1;
    #1;
    dogrulama++;
    if (sonuc_o !== 32'h0 || mesgul_o !== 1'b0 || bitti_o !== 1'b0) begin
      hata++; $display("FAIL rst_mid_outputs: got sonuc %h mesgul %b bitti %b expected 0 0 0", sonuc_o, mesgul_o, bitti_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    islem(32'd1000, 32'd7, 1'b0, 1'b1, r, g);
    dogrulama++;
    if (r !== 32'd6 || g != 33) begin hata++; $display("FAIL rst_mid_restart: got %h lat %0d expected %h lat 33", r, g, 32'd6); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", dogrulama, hata);
    $finish;
  end

endmodule
